jpeg_pix_writer: RTL and testbench
==================================

# jpeg_pix_writer

Write-back controller between the decoder's pixel output port and a single-port frame-buffer memory. Accepts the MCU-ordered RGB pixel stream (bo_* / bi_next handshake), converts each MCU-local pixel index into a raster linear address, buffers pixels in a small FIFO and issues one req/ack memory write per pixel. Also sequences the frame: arms on the first pixel, drains after the last pixel, then pulses `frame_done`.

## Interface
- `ADDR_W`, 24, memory word-address width.
- `BASE`, 0, frame-buffer base word address.
- `FIFO_DEPTH`, 8, pixel FIFO entries; power of two, ≥2.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `bo_we`  in  1  pixel valid
- `bi_next`  out  1  ready; a pixel transfers when `bo_we & bi_next`
- `bo_begin`  in  1  first pixel of frame
- `bo_end`  in  1  last pixel of frame
- `bo_r`, `bo_g`, `bo_b`  in  8 each  pixel colour
- `bo_adr`  in  8  pixel index inside MCU
- `bo_x_mcu`, `bo_y_mcu`  in  13 each  MCU column/row
- `co_411`  in  1  1: 16x16 MCU; 0: 8x8 MCU
- `co_width`, `co_heigth`  in  16 each  image size in pixels
- `co_mcu_w`  in  13  MCUs per row
- `m_req`  out  1  write request
- `m_ack`  in  1  write accepted
- `m_addr`  out  ADDR_W  word address
- `m_data`  out  24  {r,g,b}
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse when a frame has fully drained

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `bi_next`=1. A transfer with `bo_begin`=1 latches `co_411`, `co_width`, `co_heigth`, `co_mcu_w` into config registers, processes that pixel, and moves to RUN. Transfers without `bo_begin` in IDLE are accepted and discarded.
- RUN: `bi_next` = (fifo count < FIFO_DEPTH). A transfer with `bo_end`=1 moves to DRAIN. `bo_begin` and `bo_end` in the same transfer (a one-pixel frame) go IDLE→DRAIN.
- DRAIN: `bi_next`=0. Moves to DONE when the FIFO is empty and no request is outstanding.
- DONE: `frame_done`=1 for one cycle, then IDLE.
- Pixel coordinates:
  - 411: `px = x_mcu*16 + adr[3:0]`, `py = y_mcu*16 + adr[7:4]`.
  - Otherwise: `px = x_mcu*8 + adr[2:0]`, `py = y_mcu*8 + adr[5:3]`; `adr[7:6]` are ignored.
- Address: `BASE + py*stride + px`, computed at full width and truncated to ADDR_W (wraps modulo 2^ADDR_W). Stride is defined under Configuration.
- FIFO entry: {addr, rgb}. The head entry drives `m_addr`/`m_data` and `m_req`=1 while the FIFO is non-empty. `m_ack` pops the head.

## Timing
- Reset values: `bi_next`=0 during the reset cycle, 1 from the next cycle. `m_req`=0, `m_addr`=0, `m_data`=0, `busy`=0, `frame_done`=0, state IDLE, FIFO empty.
- Latency: a pixel accepted at edge N is pushed at N. `m_req` is high after N (combinational from the FIFO's non-empty flag); earliest `m_ack` is in the cycle after N.
- `m_addr`/`m_data` hold stable while `m_req`=1 and `m_ack`=0. `m_ack` while `m_req`=0 is ignored. Back-to-back acks give one write per cycle.
- Full: `bi_next`=0 when count==FIFO_DEPTH, even if `m_ack` is high in the same cycle (no push-through when full). A push and a pop in the same cycle with the FIFO non-full leave the count unchanged.
- `bi_next` depends only on registered state and count; it never depends on `bo_we` or `m_ack` combinationally.
- `rst` mid-frame: the FIFO is flushed, the state returns to IDLE, and `m_req` is 0 after the reset edge, even if a request is pending.
- Maximum throughput: 1 pixel/cycle with `m_ack` held high.

## Configuration
- `JPEG_WR_CROP_EN` defined:
  - stride = latched `co_width`.
  - Pixels with `px ≥ co_width` or `py ≥ co_heigth` are accepted but not pushed.
  - A dropped `bo_end` pixel still triggers DRAIN.
- Not defined:
  - stride = `co_mcu_w*16` (411) or `co_mcu_w*8`.
  - Every pixel is written, including MCU padding; no bounds compare logic is present.

## Test plan
- 411, `co_mcu_w`=2, `co_width`=32, BASE=0, `m_ack`=1: MCU (1,1), `adr`=0x35 → `m_addr`=16*32+... = (16+3)*32+(16+5)=629, `m_data`={r,g,b} on the cycle after acceptance.
- Non-411, `co_mcu_w`=4, `co_width`=30, `co_heigth`=30, crop on: MCU (3,0), `adr`=0x3F → px=31 dropped, no `m_req`; same pixel with crop off → `m_addr`=7*32+31=255.
- FIFO_DEPTH=8, `m_ack`=0, continuous `bo_we` → exactly 8 accepted, `bi_next`=0 from then on; one `m_ack` → `bi_next`=1 next cycle, 9th pixel accepted.
- 4-pixel frame (`bo_begin` on pixel 0, `bo_end` on pixel 3), `m_ack` every 3rd cycle → 4 writes in order, `bi_next`=0 after pixel 3, `frame_done` pulses once, one cycle after the last ack.
- `rst` asserted with 5 entries queued and `m_req`=1 → `m_req`=0, `busy`=0 next cycle; a new frame afterwards writes correct addresses with no stale entries.
- Single-pixel frame (`bo_begin`=`bo_end`=1) → one write, then `frame_done`; a pixel without `bo_begin` while IDLE → accepted, no write.

Source files
------------

// File: rtl/jpeg_pix_if.sv
// jpeg_pix_if: pixel stream, frame configuration and memory write port of jpeg_pix_writer
interface jpeg_pix_if #(parameter int ADDR_W = 24);
  logic bo_we, bi_next, bo_begin, bo_end;
  logic [7:0] bo_r, bo_g, bo_b, bo_adr;
  logic [12:0] bo_x_mcu, bo_y_mcu, co_mcu_w;
  logic co_411;
  logic [15:0] co_width, co_heigth;
  logic m_req, m_ack;
  logic [ADDR_W-1:0] m_addr;
  logic [23:0] m_data;
  logic busy, frame_done;
  modport master (
    output bo_we, bo_begin, bo_end, bo_r, bo_g, bo_b, bo_adr, bo_x_mcu, bo_y_mcu,
           co_411, co_width, co_heigth, co_mcu_w, m_ack,
    input  bi_next, m_req, m_addr, m_data, busy, frame_done
  );
  modport slave (
    input  bo_we, bo_begin, bo_end, bo_r, bo_g, bo_b, bo_adr, bo_x_mcu, bo_y_mcu,
           co_411, co_width, co_heigth, co_mcu_w, m_ack,
    output bi_next, m_req, m_addr, m_data, busy, frame_done
  );
endinterface

// File: rtl/jpeg_pix_writer.sv
// jpeg_pix_writer: MCU pixel stream to raster frame-buffer writer; define JPEG_WR_CROP_EN to crop to co_width x co_heigth
module jpeg_pix_writer #(
  parameter int ADDR_W = 24,
  parameter logic [ADDR_W-1:0] BASE = '0,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  jpeg_pix_if.slave p
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [ADDR_W+23:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count, count_n;
  logic r411, c411, xfer, keep, push, pop, empty;
  logic [47:0] px, py, stride;
  logic [ADDR_W-1:0] addr;
  // the frame's first pixel arrives in IDLE, before its config has been latched
  assign c411 = state == IDLE ? p.co_411 : r411;
  assign px = c411 ? 48'({p.bo_x_mcu, p.bo_adr[3:0]}) : 48'({p.bo_x_mcu, p.bo_adr[2:0]});
  assign py = c411 ? 48'({p.bo_y_mcu, p.bo_adr[7:4]}) : 48'({p.bo_y_mcu, p.bo_adr[5:3]});
`ifdef JPEG_WR_CROP_EN
  logic [15:0] r_width, r_heigth, width, heigth;
  assign width = state == IDLE ? p.co_width : r_width;
  assign heigth = state == IDLE ? p.co_heigth : r_heigth;
  assign stride = 48'(width);
  assign keep = px < 48'(width) && py < 48'(heigth);
  always_ff @(posedge clk)
    if (state == IDLE && xfer && p.bo_begin) begin
      r411 <= p.co_411;
      r_width <= p.co_width;
      r_heigth <= p.co_heigth;
    end
`else
  logic [12:0] r_mcu_w, mcu_w;
  assign mcu_w = state == IDLE ? p.co_mcu_w : r_mcu_w;
  assign stride = c411 ? 48'({mcu_w, 4'd0}) : 48'({mcu_w, 3'd0});
  assign keep = 1'b1;
  always_ff @(posedge clk)
    if (state == IDLE && xfer && p.bo_begin) begin
      r411 <= p.co_411;
      r_mcu_w <= p.co_mcu_w;
    end
`endif
  assign addr = ADDR_W'(48'(BASE) + py * stride + px);
  assign empty = count == '0;
  assign p.bi_next = !rst && (state == IDLE || (state == RUN && count != (PW+1)'(FIFO_DEPTH)));
  assign xfer = p.bo_we && p.bi_next;
  assign push = xfer && keep && (state == RUN || p.bo_begin);
  assign pop = p.m_ack && !empty;
  assign count_n = count + (PW+1)'(push) - (PW+1)'(pop);
  assign p.m_req = !empty;
  assign p.m_addr = empty ? '0 : mem[rp][ADDR_W+23:24];
  assign p.m_data = empty ? '0 : mem[rp][23:0];
  assign p.busy = state != IDLE;
  assign p.frame_done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= {addr, p.bo_r, p.bo_g, p.bo_b};
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count_n;
      case (state)
        IDLE: if (xfer && p.bo_begin) state <= p.bo_end ? DRAIN : RUN;
        RUN: if (xfer && p.bo_end) state <= DRAIN;
        DRAIN: if (count_n == '0) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jpeg_pix_writer.sv
// tb_jpeg_pix_writer: self-checking bench for jpeg_pix_writer; expectations follow JPEG_WR_CROP_EN when defined
module tb_jpeg_pix_writer;
  localparam longint BASE = 0;
  typedef struct {
    logic c411;
    int mw, w, h, xm, ym, adr;
    longint a_off, a_on;
    bit keep_on;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0, checks = 0, failures = 0, writes = 0, done_cnt = 0;
  int last_ack_cyc = 0, done_cyc = 0, ack_mode = 0;
  longint exp_q[$];
  bit in_frame = 0;
  bit l411;
  int lmw, lw, lh;
  jpeg_pix_if #(.ADDR_W(24)) bus();
  jpeg_pix_writer #(.ADDR_W(24), .BASE(24'd0), .FIFO_DEPTH(8)) dut (.clk(clk), .rst(rst), .p(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // frame-buffer address of a pixel, straight from the raster mapping rules
  function automatic void model(input bit c411, input int mw, w, h, xm, ym, adr,
                                output longint a, output bit keep);
    int sz = c411 ? 16 : 8;
    longint px = longint'(xm) * sz + (adr % sz);
    longint py = longint'(ym) * sz + (c411 ? adr / 16 : (adr / 8) % 8);
    longint stride;
`ifdef JPEG_WR_CROP_EN
    stride = w;
    keep = px < w && py < h;
`else
    stride = longint'(mw) * sz;
    keep = 1;
`endif
    a = (BASE + py * stride + px) & 64'hFFFFFF;
  endfunction

  always @(negedge clk) begin
    longint a, e;
    bit k;
    if (rst) begin
      exp_q.delete();
      in_frame = 0;
    end else begin
      if (bus.m_req && bus.m_ack) begin
        writes++;
        last_ack_cyc = cyc;
        chk("write_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("write_word", {bus.m_addr, bus.m_data}, e);
        end
      end
      if (bus.frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.bo_we && bus.bi_next) begin
        if (!in_frame && bus.bo_begin) begin
          in_frame = 1;
          l411 = bus.co_411;
          lmw = bus.co_mcu_w;
          lw = bus.co_width;
          lh = bus.co_heigth;
        end
        if (in_frame) begin
          model(l411, lmw, lw, lh, bus.bo_x_mcu, bus.bo_y_mcu, bus.bo_adr, a, k);
          if (k) exp_q.push_back((a << 24) | longint'({bus.bo_r, bus.bo_g, bus.bo_b}));
          if (bus.bo_end) in_frame = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ack_mode == 1) bus.m_ack = 1'($urandom_range(0, 1));
    else if (ack_mode == 2) bus.m_ack = (cyc % 3 == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cfg(input bit c411, input int mw, w, h);
    bus.co_411 = c411;
    bus.co_mcu_w = 13'(mw);
    bus.co_width = 16'(w);
    bus.co_heigth = 16'(h);
  endtask

  task automatic pix(input bit b, e, input int xm, ym, adr, input logic [23:0] rgb);
    bit acc = 0;
    bus.bo_we = 1;
    bus.bo_begin = b;
    bus.bo_end = e;
    bus.bo_x_mcu = 13'(xm);
    bus.bo_y_mcu = 13'(ym);
    bus.bo_adr = 8'(adr);
    {bus.bo_r, bus.bo_g, bus.bo_b} = rgb;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.bi_next;
      @(posedge clk);
      #1;
    end
    chk("pixel_accepted", acc, 1);
    bus.bo_we = 0;
    bus.bo_begin = 0;
    bus.bo_end = 0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = bus.frame_done;
      @(posedge clk);
      #1;
    end
    chk(name, seen, 1);
  endtask

  initial begin
    vec_t tv[6];
    int acc, w0, d0, n;
    longint ea;
    bit kp;
    logic [23:0] rgb;
    bus.bo_we = 0; bus.bo_begin = 0; bus.bo_end = 0;
    bus.bo_r = 0; bus.bo_g = 0; bus.bo_b = 0; bus.bo_adr = 0;
    bus.bo_x_mcu = 0; bus.bo_y_mcu = 0; bus.m_ack = 0;
    cfg(0, 1, 8, 8);
    tv[0] = '{1'b1, 2, 32, 32, 1, 1, 'h35, 629, 629, 1'b1};
    tv[1] = '{1'b0, 4, 30, 30, 3, 0, 'h3F, 255, 0, 1'b0};
    tv[2] = '{1'b0, 10, 80, 60, 0, 0, 'h00, 0, 0, 1'b1};
    tv[3] = '{1'b0, 10, 80, 60, 9, 7, 'hFF, 5119, 0, 1'b0};
    tv[4] = '{1'b1, 5, 70, 48, 4, 2, 'hA3, 3427, 3007, 1'b1};
    tv[5] = '{1'b1, 8191, 65535, 65535, 8190, 8190, 'hFF, 12583167, 0, 1'b0};

    @(posedge clk);
    @(negedge clk);
    chk("rst_bi_next", bus.bi_next, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_bi_next_after", bus.bi_next, 1);
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    @(posedge clk);
    #1;

    bus.m_ack = 1;
    foreach (tv[i]) begin
      rgb = 24'($urandom);
      cfg(tv[i].c411, tv[i].mw, tv[i].w, tv[i].h);
      pix(1, 1, tv[i].xm, tv[i].ym, tv[i].adr, rgb);
      @(negedge clk);
`ifdef JPEG_WR_CROP_EN
      ea = tv[i].a_on;
      kp = tv[i].keep_on;
`else
      ea = tv[i].a_off;
      kp = 1;
`endif
      chk("vec_m_req", bus.m_req, kp);
      if (kp) begin
        chk("vec_m_addr", bus.m_addr, ea);
        chk("vec_m_data", bus.m_data, rgb);
      end
      @(posedge clk);
      #1;
      wait_done("vec_frame_done");
    end

    bus.m_ack = 0;
    w0 = writes;
    cfg(0, 4, 32, 32);
    bus.bo_we = 1; bus.bo_begin = 1; bus.bo_end = 0;
    bus.bo_x_mcu = 0; bus.bo_y_mcu = 0; bus.bo_adr = 0;
    acc = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.bi_next) acc++;
      @(posedge clk);
      #1;
      bus.bo_begin = 0;
      bus.bo_adr = 8'(acc);
      bus.bo_r = 8'($urandom);
    end
    chk("full_accepts", acc, 8);
    bus.bo_end = 1;
    bus.m_ack = 1;
    @(negedge clk);
    chk("full_no_pushthrough", bus.bi_next, 0);
    chk("full_m_req", bus.m_req, 1);
    @(posedge clk);
    #1 bus.m_ack = 0;
    @(negedge clk);
    chk("full_reopen", bus.bi_next, 1);
    @(posedge clk);
    #1;
    bus.bo_we = 0;
    bus.bo_end = 0;
    @(negedge clk);
    chk("drain_bi_next", bus.bi_next, 0);
    @(posedge clk);
    #1 bus.m_ack = 1;
    wait_done("full_frame_done");
    chk("full_writes", writes - w0, 9);

    bus.m_ack = 0;
    w0 = writes;
    d0 = done_cnt;
    cfg(1, 3, 48, 48);
    ack_mode = 2;
    for (int i = 0; i < 4; i++) pix(i == 0, i == 3, 2, 1, $urandom_range(0, 255), 24'($urandom));
    @(negedge clk);
    chk("c_bi_next_after_end", bus.bi_next, 0);
    chk("c_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    wait_done("c_frame_done");
    repeat (4) @(posedge clk);
    #1;
    ack_mode = 0;
    bus.m_ack = 0;
    chk("c_writes", writes - w0, 4);
    chk("c_done_once", done_cnt - d0, 1);
    chk("c_done_latency", done_cyc - last_ack_cyc, 1);

    cfg(0, 4, 32, 32);
    for (int i = 0; i < 5; i++) pix(i == 0, 0, 1, 1, i, 24'($urandom));
    @(negedge clk);
    chk("d_m_req_pending", bus.m_req, 1);
    chk("d_busy_pending", bus.busy, 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("d_m_req_after_rst", bus.m_req, 0);
    chk("d_busy_after_rst", bus.busy, 0);
    @(posedge clk);
    #1;
    w0 = writes;
    bus.m_ack = 1;
    cfg(1, 2, 32, 32);
    for (int i = 0; i < 3; i++) pix(i == 0, i == 2, 1, 0, 17 * i, 24'($urandom));
    wait_done("d_frame_done");
    chk("d_writes", writes - w0, 3);
    chk("d_no_stale", exp_q.size(), 0);

    w0 = writes;
    pix(0, 0, 0, 0, 5, 24'h123456);
    @(negedge clk);
    chk("e_m_req", bus.m_req, 0);
    chk("e_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("e_writes", writes - w0, 0);

    ack_mode = 1;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        cfg(1'($urandom_range(0, 1)), $urandom_range(1, 20), $urandom_range(1, 400), $urandom_range(1, 400));
        pix(i == 0, i == n - 1, $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 255), 24'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      wait_done("rand_frame_done");
      chk("rand_queue_empty", exp_q.size(), 0);
    end
    ack_mode = 0;
    bus.m_ack = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
